switch_conditioner: RTL and testbench
=====================================

Name: switch_conditioner

Overview:
- Upstream input stage for the 4-bit CPU top level on the Go Board.
- Takes the raw, asynchronous, bouncing SW1..SW4 pins and produces clean signals for the CPU: synchronized, debounced levels, single-cycle press/release pulses and a long-press hold flag.
- The CPU start input consumes a press pulse. The CPU reset path consumes the debounced level or the hold flag.

Parameters:
- NUM_SW, 4: number of switch channels.
- DEBOUNCE_CYCLES, 250000: consecutive CLK cycles a new level must persist before it is accepted (10 ms at 25 MHz); must be >= 2.
- HOLD_CYCLES, 25000000: cycles of continuous debounced press before held asserts (1 s); must be > DEBOUNCE_CYCLES.
- INVERT_MASK, 4'b0000: per-bit; a 1 means the raw pin is active-low (pressed = 0).

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous, active-high reset.
- sw_raw  input  NUM_SW  raw switch pins, asynchronous to CLK.
- sw_level  output  NUM_SW  debounced level; 1 = pressed, after INVERT_MASK is applied.
- sw_press  output  NUM_SW  one-cycle pulse on each accepted released->pressed transition.
- sw_release  output  NUM_SW  one-cycle pulse on each accepted pressed->released transition.
- sw_held  output  NUM_SW  high while pressed continuously for >= HOLD_CYCLES.

Behaviour:
- Channels are independent and identical; the rules below apply per bit i.
- Polarity: n = sw_raw[i] XOR INVERT_MASK[i].
- Synchronizer:
  - n passes through two flops, s1 then s2.
  - s2 reflects n after 2 rising edges.
  - Only s2 is used downstream.
- Debounce states:
  - RELEASED (stable = 0) and PRESSED (stable = 1).
  - Counter cnt has width clog2(DEBOUNCE_CYCLES).
- Each edge, when s2 == stable:
  - cnt <= 0.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is discarded.
- Each edge, when s2 != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
- Each edge, when s2 != stable and cnt == DEBOUNCE_CYCLES-1:
  - stable <= s2 and cnt <= 0.
  - On the same edge, sw_press (if s2 = 1) or sw_release (if s2 = 0) is registered high for exactly one cycle.
- sw_level = stable (registered).
- Latency: a clean step on sw_raw appears on sw_level and the pulse after 2 + DEBOUNCE_CYCLES rising edges.
- Hold counter:
  - hcnt, width clog2(HOLD_CYCLES+1).
  - Cleared while stable = 0.
  - Increments while stable = 1 and saturates at HOLD_CYCLES.
  - sw_held = (hcnt == HOLD_CYCLES), registered.
  - Deasserts on the same edge that stable returns to 0.
- sw_held produces no pulse and asserts only once per press.
- sw_press and sw_release are never high together on one channel. Pulses on different channels may coincide.
- Reset (RST = 1 at an edge):
  - s1, s2, stable, cnt, hcnt and all outputs clear to 0.
  - A switch held through reset is re-qualified after release of RST: sw_press fires after 2 + DEBOUNCE_CYCLES edges.
  - Reset mid-count aborts the count with no pulse.
- Counter wrap: cnt never exceeds DEBOUNCE_CYCLES-1 and hcnt never exceeds HOLD_CYCLES; neither wraps.
- No combinational path from sw_raw to any output.

Test Plan (DEBOUNCE_CYCLES = 4, HOLD_CYCLES = 10, INVERT_MASK = 4'b0001):
- Reset:
  - Stimulus: RST = 1 for 3 cycles, sw_raw = 4'b0001.
  - Required: all outputs 0; channel 0 reads released.
  - After RST = 0, outputs stay 0 for >= 20 cycles.
- Clean press on bit 1:
  - Stimulus: raw 0 -> 1 held.
  - Required: sw_level[1] rises exactly 6 edges later; sw_press[1] = 1 for exactly one cycle on that edge; sw_release stays 0.
- Bounce rejection:
  - Stimulus: bit 2 toggles 1, 0, 1, 0 every 2 cycles, then holds 1.
  - Required: exactly one sw_press[2], 6 edges after the final rise; no sw_release[2].
- Hold:
  - Stimulus: bit 3 pressed for 20 cycles after debounce.
  - Required: sw_held[3] rises 10 edges after sw_level[3].
  - On release, sw_held[3] and sw_level[3] fall on the same edge, together with one sw_release[3] pulse.
- Inverted channel:
  - Stimulus: sw_raw[0] driven 1 -> 0.
  - Required: sw_level[0] rises after 6 edges with one sw_press[0].
- Reset mid-debounce:
  - Stimulus: RST asserted 3 edges after a bit 1 raw press, then released with the raw input still pressed.
  - Required: no pulse during or before reset; sw_press[1] fires 6 edges after RST falls.

Source files
------------

// File: rtl/switch_conditioner.sv
// switch_conditioner: synchronizes, debounces and edge/hold-qualifies raw switch pins
module switch_conditioner #(
  parameter int NUM_SW = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES = 25000000,
  parameter logic [NUM_SW-1:0] INVERT_MASK = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NUM_SW-1:0] sw_raw,
  output logic [NUM_SW-1:0] sw_level,
  output logic [NUM_SW-1:0] sw_press,
  output logic [NUM_SW-1:0] sw_release,
  output logic [NUM_SW-1:0] sw_held
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HMAX = HW'(HOLD_CYCLES);
  logic [NUM_SW-1:0] s1, s2;
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_raw ^ INVERT_MASK;
      s2 <= s1;
    end
  end
  for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
    logic [CW-1:0] cnt, cnt_n;
    logic [HW-1:0] hcnt, hcnt_n;
    logic stable, stable_n, flip, press, release_p, held;
    always_comb begin
      flip = (s2[i] != stable) && (cnt == CMAX);
      stable_n = flip ? s2[i] : stable;
      cnt_n = (s2[i] == stable || flip) ? '0 : cnt + 1'b1;
      // hold time starts on the edge after the press is accepted and drops on the release edge
      hcnt_n = !(stable && stable_n) ? '0 : (hcnt == HMAX) ? hcnt : hcnt + 1'b1;
    end
    always_ff @(posedge CLK) begin
      if (RST) begin
        cnt <= '0;
        hcnt <= '0;
        stable <= 1'b0;
        press <= 1'b0;
        release_p <= 1'b0;
        held <= 1'b0;
      end else begin
        cnt <= cnt_n;
        hcnt <= hcnt_n;
        stable <= stable_n;
        press <= flip && s2[i];
        release_p <= flip && !s2[i];
        held <= (hcnt_n == HMAX);
      end
    end
    assign sw_level[i] = stable;
    assign sw_press[i] = press;
    assign sw_release[i] = release_p;
    assign sw_held[i] = held;
  end
endmodule

// File: tb/tb_switch_conditioner.sv
// tb_switch_conditioner: directed edge-count checks plus random bouncing against a window-based model
module tb_switch_conditioner;
  localparam int D = 4;
  localparam int H = 10;
  localparam logic [3:0] INV = 4'b0001;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [3:0] sw_raw = 4'b0001;
  logic [3:0] sw_level, sw_press, sw_release, sw_held;
  int n_cmp = 0;
  int n_bad = 0;
  int presses[4];
  int releases[4];
  bit chk_en = 1'b0;

  switch_conditioner #(.NUM_SW(4), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .INVERT_MASK(INV)) dut (
    .CLK(CLK), .RST(RST), .sw_raw(sw_raw), .sw_level(sw_level),
    .sw_press(sw_press), .sw_release(sw_release), .sw_held(sw_held)
  );

  always #5 CLK = ~CLK;

  // Model: a level is accepted once the last D synchronized samples all disagree with it.
  logic [3:0] hist [0:D];
  logic [3:0] m_level = '0, m_press = '0, m_rel = '0, m_held = '0;
  int age[4];
  bit all_diff;
  always @(posedge CLK) begin
    if (RST) begin
      for (int j = 0; j <= D; j++) hist[j] = '0;
      m_level = '0; m_press = '0; m_rel = '0; m_held = '0;
      for (int c = 0; c < 4; c++) age[c] = 0;
    end else begin
      m_press = '0;
      m_rel = '0;
      for (int c = 0; c < 4; c++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= D; j++) if (hist[j][c] == m_level[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[c] = ~m_level[c];
          if (m_level[c]) m_press[c] = 1'b1;
          else m_rel[c] = 1'b1;
          age[c] = 0;
        end else if (m_level[c]) age[c]++;
        m_held[c] = m_level[c] && (age[c] >= H);
      end
      for (int j = D; j >= 1; j--) hist[j] = hist[j-1];
      hist[0] = sw_raw ^ INV;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      n_cmp++;
      if ({sw_level, sw_press, sw_release, sw_held} !== {m_level, m_press, m_rel, m_held}) begin
        n_bad++;
        $display("FAIL outputs @%0t: got lvl=%b prs=%b rel=%b hld=%b want lvl=%b prs=%b rel=%b hld=%b",
                 $time, sw_level, sw_press, sw_release, sw_held, m_level, m_press, m_rel, m_held);
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    for (int c = 0; c < 4; c++) begin
      presses[c] += int'(sw_press[c]);
      releases[c] += int'(sw_release[c]);
    end
  endtask

  task automatic clr();
    for (int c = 0; c < 4; c++) begin
      presses[c] = 0;
      releases[c] = 0;
    end
  endtask

  task automatic wait_level(input int ch, input logic v, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (sw_level[ch] !== v && n < 40);
  endtask

  int n, k;
  bit idle_ok;
  int rate;

  initial begin
    clr();
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    check("reset_outputs", int'({sw_level, sw_press, sw_release, sw_held}), 0);
    check("reset_ch0_released", int'(sw_level[0]), 0);
    RST = 1'b0;
    idle_ok = 1'b1;
    repeat (20) begin
      tick();
      if ({sw_level, sw_press, sw_release, sw_held} !== 16'h0) idle_ok = 1'b0;
    end
    check("idle_after_reset", int'(idle_ok), 1);

    clr();
    sw_raw[1] = 1'b1;
    wait_level(1, 1'b1, n);
    check("press1_latency", n, 6);
    check("press1_pulse_now", int'(sw_press[1]), 1);
    tick();
    check("press1_pulse_gone", int'(sw_press[1]), 0);
    check("press1_count", presses[1], 1);
    check("press1_no_release", releases[1], 0);

    clr();
    sw_raw[2] = 1'b1; tick(); tick();
    sw_raw[2] = 1'b0; tick(); tick();
    sw_raw[2] = 1'b1; tick(); tick();
    sw_raw[2] = 1'b0; tick(); tick();
    check("bounce_no_pulse", presses[2] + releases[2], 0);
    sw_raw[2] = 1'b1;
    wait_level(2, 1'b1, n);
    check("bounce_latency", n, 6);
    repeat (3) tick();
    check("bounce_one_press", presses[2], 1);
    check("bounce_no_release", releases[2], 0);

    clr();
    sw_raw[3] = 1'b1;
    wait_level(3, 1'b1, n);
    check("hold_debounce", n, 6);
    k = 0;
    while (!sw_held[3] && k < 40) begin
      tick();
      k++;
    end
    check("hold_delay", k, 10);
    repeat (10) tick();
    check("hold_still_high", int'(sw_held[3]), 1);
    clr();
    sw_raw[3] = 1'b0;
    wait_level(3, 1'b0, n);
    check("hold_release_latency", n, 6);
    check("hold_drops_with_level", int'(sw_held[3]), 0);
    check("hold_release_pulse", int'(sw_release[3]), 1);
    check("hold_release_count", releases[3], 1);

    clr();
    sw_raw[0] = 1'b0;
    wait_level(0, 1'b1, n);
    check("inv_latency", n, 6);
    check("inv_press", presses[0], 1);

    sw_raw[1] = 1'b0;
    wait_level(1, 1'b0, n);
    check("ch1_release_latency", n, 6);
    clr();
    sw_raw[1] = 1'b1;
    tick(); tick();
    RST = 1'b1;
    tick(); tick(); tick();
    check("midreset_no_pulse", presses[1] + releases[1], 0);
    check("midreset_cleared", int'({sw_level, sw_held}), 0);
    RST = 1'b0;
    clr();
    wait_level(1, 1'b1, n);
    check("midreset_requalify", n, 6);
    check("midreset_press", presses[1], 1);

    for (int blk = 0; blk < 15; blk++) begin
      rate = (blk % 3 == 0) ? 2 : (blk % 3 == 1) ? 5 : 20;
      for (int c = 0; c < 200; c++) begin
        for (int b = 0; b < 4; b++)
          if ($urandom_range(0, rate) == 0) sw_raw[b] = ~sw_raw[b];
        RST = ($urandom_range(0, 599) == 0);
        tick();
      end
    end
    RST = 1'b0;
    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
